if_stage: RTL and testbench

- Instruction-fetch stage of the LC-3b pipeline; sits directly upstream of the hazard/bubble-insertion stage.
- Owns the PC and drives the instruction-memory read handshake.
- Presents the fetched instruction and its PC to the hazard stage; honours that stage's pc_ld and the global stall.
- Accepts taken-branch/JSR/TRAP redirects from later stages and squashes wrong-path fetches.

---
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read handshake and
// hands fetched words (or bubbles) to the hazard stage, squashing wrong-path reads.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_ld,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    output logic [15:0] ir_val,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic [15:0] fetch_bubbles
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] squash_addr, squash_addr_nxt;
    logic [15:0] hold_data, hold_data_nxt;
    logic [15:0] hold_pc, hold_pc_nxt;
    logic [15:0] ir_nxt, pc_out_nxt, bubbles_nxt;
    logic        valid_nxt;
    logic        advance;
    logic        bubble;

    assign advance  = pc_ld & ~stall;
    assign pc_plus2 = pc_out + 16'd2;

    always_comb begin
        imem_read    = 1'b0;
        imem_address = pc;
        case (state)
            FETCH:   imem_read = rst_n;
            SQUASH: begin
                imem_read    = rst_n;
                imem_address = squash_addr;
            end
            default: imem_read = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        squash_addr_nxt = squash_addr;
        hold_data_nxt   = hold_data;
        hold_pc_nxt     = hold_pc;
        ir_nxt          = ir_val;
        pc_out_nxt      = pc_out;
        valid_nxt       = if_valid;
        bubble          = 1'b0;

        if (redirect_valid) begin
            pc_nxt = redirect_pc & 16'hFFFE;
            bubble = advance;
            case (state)
                FETCH: begin
                    if (!imem_resp) begin
                        state_nxt       = SQUASH;
                        squash_addr_nxt = pc;
                    end
                end
                HOLD:    state_nxt = FETCH;
                // A response landing with a fresh redirect still ends the wrong-path read.
                SQUASH:  state_nxt = imem_resp ? FETCH : SQUASH;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_resp && advance) begin
                        ir_nxt     = imem_rdata;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + 16'd2;
                    end else if (imem_resp) begin
                        hold_data_nxt = imem_rdata;
                        hold_pc_nxt   = pc;
                        state_nxt     = HOLD;
                    end else begin
                        bubble = advance;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        ir_nxt     = hold_data;
                        pc_out_nxt = hold_pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + 16'd2;
                        state_nxt  = FETCH;
                    end
                end
                SQUASH: begin
                    bubble = advance;
                    if (imem_resp) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end

        if (bubble) begin
            ir_nxt    = NOP_WORD;
            valid_nxt = 1'b0;
        end

        bubbles_nxt = fetch_bubbles;
        if (bubble && fetch_bubbles != 16'hFFFF) bubbles_nxt = fetch_bubbles + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            squash_addr   <= RESET_PC;
            hold_data     <= NOP_WORD;
            hold_pc       <= RESET_PC;
            ir_val        <= NOP_WORD;
            pc_out        <= RESET_PC;
            if_valid      <= 1'b0;
            fetch_bubbles <= '0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            squash_addr   <= squash_addr_nxt;
            hold_data     <= hold_data_nxt;
            hold_pc       <= hold_pc_nxt;
            ir_val        <= ir_nxt;
            pc_out        <= pc_out_nxt;
            if_valid      <= valid_nxt;
            fetch_bubbles <= bubbles_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each cycle's expected registered outputs are
// queued when the stimulus is driven and popped after the clock edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_ld;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic [15:0] ir_val;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        if_valid;
    logic [15:0] fetch_bubbles;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          step;
        logic [15:0] ir;
        logic [15:0] pco;
        logic        v;
        logic [15:0] bub;
    } exp_t;

    exp_t sb[$];

    if_stage #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_ld         (pc_ld),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .ir_val        (ir_val),
        .pc_out        (pc_out),
        .pc_plus2      (pc_plus2),
        .if_valid      (if_valid),
        .fetch_bubbles (fetch_bubbles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int step, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s step %0d: got %h want %h", name, step, obs, exp);
    endtask

    // One clock: drive inputs, check the combinational request (when asked),
    // queue the post-edge expectation, then compare after the edge.
    task automatic cyc(input int step, input logic rstn,
                       input logic resp, input logic [15:0] rd,
                       input logic ld, input logic stl,
                       input logic rv, input logic [15:0] rpc,
                       input logic exp_read, input logic chk_addr, input logic [15:0] exp_addr,
                       input logic [15:0] e_ir, input logic [15:0] e_pco,
                       input logic e_v, input logic [15:0] e_bub);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n          = rstn;
        imem_resp      = resp;
        imem_rdata     = rd;
        pc_ld          = ld;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("imem_read", step, {15'd0, imem_read}, {15'd0, exp_read});
        if (chk_addr) chk("imem_address", step, imem_address, exp_addr);
        e.step = step; e.ir = e_ir; e.pco = e_pco; e.v = e_v; e.bub = e_bub;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            $error("FAIL scoreboard step %0d: got empty queue want entry", step);
        end else begin
            got = sb.pop_front();
            chk("ir_val", got.step, ir_val, got.ir);
            chk("pc_out", got.step, pc_out, got.pco);
            chk("if_valid", got.step, {15'd0, if_valid}, {15'd0, got.v});
            chk("fetch_bubbles", got.step, fetch_bubbles, got.bub);
            chk("pc_plus2", got.step, pc_plus2, got.pco + 16'd2);
        end
    endtask

    initial begin
        rst_n = 1'b0; pc_ld = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_rdata = '0; imem_resp = 1'b0;

        //  step rst resp rdata     ld  st  rv  rpc       rd  ca  addr      ir        pco       v   bub
        cyc( 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc( 1, 0, 1, 16'h9999, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        // back-to-back single-cycle fetches
        cyc( 2, 1, 1, 16'h1234, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h1234, 16'h0000, 1, 16'd0);
        cyc( 3, 1, 1, 16'h5678, 1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h5678, 16'h0002, 1, 16'd0);
        // response under stall lands in the hold buffer
        cyc( 4, 1, 1, 16'hABCD, 1, 1, 0, 16'h0000, 1, 1, 16'h0004, 16'h5678, 16'h0002, 1, 16'd0);
        cyc( 5, 1, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h5678, 16'h0002, 1, 16'd0);
        cyc( 6, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'hABCD, 16'h0004, 1, 16'd0);
        // three-cycle latency: two bubbles
        cyc( 7, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000, 16'h0004, 0, 16'd1);
        cyc( 8, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000, 16'h0004, 0, 16'd2);
        cyc( 9, 1, 1, 16'h1111, 1, 0, 0, 16'h0000, 1, 1, 16'h0006, 16'h1111, 16'h0006, 1, 16'd2);
        // redirect with read of 0008 outstanding: squash, wrong-path data dropped
        cyc(10, 1, 0, 16'h0000, 1, 0, 1, 16'h3001, 1, 1, 16'h0008, 16'h0000, 16'h0006, 0, 16'd3);
        cyc(11, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0008, 16'h0000, 16'h0006, 0, 16'd4);
        cyc(12, 1, 1, 16'hDEAD, 1, 0, 0, 16'h0000, 1, 1, 16'h0008, 16'h0000, 16'h0006, 0, 16'd5);
        cyc(13, 1, 1, 16'h2222, 1, 0, 0, 16'h0000, 1, 1, 16'h3000, 16'h2222, 16'h3000, 1, 16'd5);
        // redirect coincident with a response, no advance: outputs hold
        cyc(14, 1, 1, 16'hBEEF, 0, 0, 1, 16'hFFFE, 1, 1, 16'h3002, 16'h2222, 16'h3000, 1, 16'd5);
        // fetch at FFFE: pc_plus2 and next address wrap to 0000
        cyc(15, 1, 1, 16'h3333, 1, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 16'h3333, 16'hFFFE, 1, 16'd5);
        cyc(16, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h3333, 16'hFFFE, 1, 16'd5);
        cyc(17, 1, 1, 16'h4444, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h4444, 16'h0000, 1, 16'd5);
        cyc(18, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h0000, 16'h0000, 0, 16'd6);
        // reset with a read outstanding
        cyc(19, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(20, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        // reset while in HOLD discards the buffered word
        cyc(21, 1, 1, 16'h5555, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(22, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(23, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(24, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(25, 1, 1, 16'h6666, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h6666, 16'h0000, 1, 16'd0);
        // redirect from HOLD with advance: bubble, then fetch at target
        cyc(26, 1, 1, 16'h7777, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'h6666, 16'h0000, 1, 16'd0);
        cyc(27, 1, 0, 16'h0000, 1, 0, 1, 16'h4000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd1);
        cyc(28, 1, 1, 16'h8888, 1, 0, 0, 16'h0000, 1, 1, 16'h4000, 16'h8888, 16'h4000, 1, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
